// File: rtl/fft_stream_bridge_if.sv
// Stream, sample-RAM and FFT-engine handshake bundle for the FFT stream bridge.
// No storage; pure signal grouping.
// master = bridge side, slave = stream source/sink, RAM and FFT engine side.
interface fft_stream_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  calc_start;
  logic                  calc_done;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready, ram_rdata, calc_done,
    output s_tready, m_tdata, m_tvalid, m_tlast, ram_we, ram_re, ram_addr, ram_wdata, calc_start
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready, ram_rdata, calc_done,
    input  s_tready, m_tdata, m_tvalid, m_tlast, ram_we, ram_re, ram_addr, ram_wdata, calc_start
  );
endinterface

// File: rtl/fft_stream_bridge.sv
// Loads one frame into sample RAM (optionally bit-reversed), kicks the FFT, drains RAM to a stream.
// Latency: input write is combinational; first output beat RD_LAT cycles after the first RAM read.
// Backpressure: input stalls outside IDLE/LOAD; reads are credit-limited by an RD_LAT+1 deep output FIFO.
module fft_stream_bridge #(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 12,
  parameter int  RD_LAT     = 1,
  localparam int LW         = $clog2(ADDR_WIDTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [LW-1:0]        i_log2_n,
  input  logic                 i_bitrev,
  fft_stream_bridge_if.master  bus_if,
  output logic                 o_busy,
  output logic                 o_err_len
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CNTW  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FILL, ST_CALC, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         n_q, n_d, n_in;
  logic                  br_q, br_d;
  logic [CNTW-1:0]       cnt_q, cnt_d, rd_q, rd_d, out_q, out_d, last_idx;
  logic                  err_q, err_d;
  logic                  run_q, calc_q;
  logic [RD_LAT-1:0]     pipe_q;
  logic [CW-1:0]         infl_q, infl_d, fcnt_q, fcnt_d;
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  s_rdy, s_hs, re, ret, f_empty, m_vld, m_hs, push, pop, we;
  logic [ADDR_WIDTH-1:0] widx, waddr;
  logic [DATA_WIDTH-1:0] wdat, m_dat;

  // Bit-reverse the low n bits of idx when br is set, upper bits stay 0.
  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] idx,
                                                     input logic [LW-1:0] n, input logic br);
    logic [ADDR_WIDTH-1:0] rev;
    rev = {<<{idx}};
    if (br) return rev >> (LW'(ADDR_WIDTH) - n);
    return idx;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Clamp the requested frame exponent into 1..ADDR_WIDTH.
  always_comb begin
    n_in = i_log2_n;
    if (i_log2_n == '0) n_in = LW'(1);
    else if (i_log2_n > LW'(ADDR_WIDTH)) n_in = LW'(ADDR_WIDTH);
  end

  assign last_idx = (CNTW'(1) << n_q) - CNTW'(1);
  assign s_rdy    = run_q && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign s_hs     = s_rdy && bus_if.s_tvalid;
  assign ret      = pipe_q[RD_LAT-1];
  assign f_empty  = (fcnt_q == '0);
  // Returning RAM data bypasses an empty FIFO so the first beat appears RD_LAT cycles after its read.
  assign m_vld    = (state_q == ST_DRAIN) && (!f_empty || ret);
  assign m_dat    = f_empty ? bus_if.ram_rdata : mem_q[rp_q];
  assign m_hs     = m_vld && bus_if.m_tready;
  assign push     = ret && !(f_empty && bus_if.m_tready);
  assign pop      = !f_empty && m_hs;
  assign re       = (state_q == ST_DRAIN) && (rd_q <= last_idx) &&
                    (({1'b0, fcnt_q} + {1'b0, infl_q}) < (CW+1)'(DEPTH));

  // Next-state and write-side control.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    out_d   = out_q;
    err_d   = err_q;
    we      = 1'b0;
    widx    = cnt_q[ADDR_WIDTH-1:0];
    wdat    = bus_if.s_tdata;
    case (state_q)
      ST_IDLE: if (s_hs) begin
        we      = 1'b1;
        widx    = '0;
        n_d     = n_in;
        br_d    = i_bitrev;
        cnt_d   = CNTW'(1);
        err_d   = bus_if.s_tlast;
        state_d = bus_if.s_tlast ? ST_FILL : ST_LOAD;
      end
      ST_LOAD: if (s_hs) begin
        we    = 1'b1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == last_idx) begin
          state_d = ST_CALC;
          if (!bus_if.s_tlast) err_d = 1'b1;
        end else if (bus_if.s_tlast) begin
          err_d   = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        we    = 1'b1;
        wdat  = '0;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == last_idx) state_d = ST_CALC;
      end
      ST_CALC: if (calc_q && bus_if.calc_done) begin
        state_d = ST_DRAIN;
        rd_d    = '0;
        out_d   = '0;
      end
      ST_DRAIN: begin
        if (re) rd_d = rd_q + CNTW'(1);
        if (m_hs) begin
          out_d = out_q + CNTW'(1);
          if (out_q == last_idx) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign waddr  = map_addr(widx, n_q, br_q);
  assign infl_d = infl_q + CW'(re) - CW'(ret);
  assign fcnt_d = fcnt_q + CW'(push) - CW'(pop);
  assign wp_d   = push ? next_ptr(wp_q) : wp_q;
  assign rp_d   = pop ? next_ptr(rp_q) : rp_q;

  // State, counters, read-latency pipe and FIFO pointers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      n_q     <= LW'(1);
      br_q    <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      calc_q  <= 1'b0;
      pipe_q  <= '0;
      infl_q  <= '0;
      fcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      out_q   <= out_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
      calc_q  <= (state_q == ST_CALC);
      pipe_q  <= (pipe_q << 1) | RD_LAT'(re);
      infl_q  <= infl_d;
      fcnt_q  <= fcnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Output FIFO storage; only occupancy needs reset.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wp_q] <= bus_if.ram_rdata;
  end

  assign bus_if.s_tready   = s_rdy;
  assign bus_if.m_tvalid   = m_vld;
  assign bus_if.m_tdata    = m_vld ? m_dat : '0;
  assign bus_if.m_tlast    = m_vld && (out_q == last_idx);
  assign bus_if.ram_we     = we;
  assign bus_if.ram_re     = re;
  assign bus_if.ram_addr   = we ? waddr : (re ? rd_q[ADDR_WIDTH-1:0] : '0);
  assign bus_if.ram_wdata  = we ? wdat : '0;
  assign bus_if.calc_start = (state_q == ST_CALC) && !calc_q;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_err_len         = err_q;
endmodule
